// File: rtl/pipe_hazard_ctrl.sv
// Issue/hazard controller for the 3-stage ID -> EX -> WB ADD/SUB/LOAD pipeline.
// Latency: an instruction that issues at edge T is in EX during T+1 and writes back during T+2 (freeze cycles add to this).
// Backpressure: mem_busy freezes EX/WB and blocks issue; a load-use hazard holds ID for one cycle; flush drops ID.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   id_valid/opcode/rd/rs1/rs2 instruction presented in ID (rs2 is an immediate for LOAD)
//   mem_busy                   data memory not ready: freeze EX and WB, block issue
//   flush                      discard the ID instruction this cycle
//   id_ready, stall, load_use  issue decision and stall causes for the ID stage
//   ex_valid/opcode/rd         contents of the EX slot
//   ex_fwd_a, ex_fwd_b         EX operand takes the WB result instead of the regfile
//   wb_en, wb_rd               register-file write port control
// Optional (HAZ_STALL_CNT_EN defined): stall_cycles, load_use_cycles, freeze_cycles
//   saturating 16-bit event counters.

module pipe_hazard_ctrl #(
  parameter int          NREG    = 16,
  parameter logic [3:0]  OP_ADD  = 4'b0001,
  parameter logic [3:0]  OP_SUB  = 4'b0010,
  parameter logic [3:0]  OP_LOAD = 4'b0011
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [3:0]                id_opcode,
  input  logic [$clog2(NREG)-1:0]   id_rd,
  input  logic [$clog2(NREG)-1:0]   id_rs1,
  input  logic [$clog2(NREG)-1:0]   id_rs2,
  input  logic                      mem_busy,
  input  logic                      flush,
  output logic                      id_ready,
  output logic                      stall,
  output logic                      load_use,
  output logic                      ex_valid,
  output logic [3:0]                ex_opcode,
  output logic [$clog2(NREG)-1:0]   ex_rd,
  output logic                      ex_fwd_a,
  output logic                      ex_fwd_b,
  output logic                      wb_en,
  output logic [$clog2(NREG)-1:0]   wb_rd
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [15:0]               stall_cycles,
  output logic [15:0]               load_use_cycles,
  output logic [15:0]               freeze_cycles
`endif
);

  localparam int RW = $clog2(NREG);

  // WB slot state; EX slot state lives directly in the ex_* output registers.
  logic          wb_valid;
  logic [RW-1:0] wb_rd_q;

  // Source/destination usage decode for the ID instruction and the EX occupant.
  logic id_uses_rs1;
  logic id_uses_rs2;
  logic ex_is_alu;
  logic ex_is_load;
  logic ex_writes;
  logic hit_rs1;
  logic hit_rs2;
  logic fwd_a_nxt;
  logic fwd_b_nxt;

  always_comb begin
    id_uses_rs1 = (id_opcode == OP_ADD) || (id_opcode == OP_SUB) || (id_opcode == OP_LOAD);
    id_uses_rs2 = (id_opcode == OP_ADD) || (id_opcode == OP_SUB);
    ex_is_alu   = (ex_opcode == OP_ADD) || (ex_opcode == OP_SUB);
    ex_is_load  = (ex_opcode == OP_LOAD);
    ex_writes   = ex_valid && (ex_is_alu || ex_is_load);

    hit_rs1 = id_uses_rs1 && (ex_rd == id_rs1);
    hit_rs2 = id_uses_rs2 && (ex_rd == id_rs2);

    // A load's data only exists at the end of EX, so a consumer right behind it
    // must wait one cycle; it then reads the regfile after the load's write.
    load_use = id_valid && ex_valid && ex_is_load && (hit_rs1 || hit_rs2);

    id_ready = id_valid && !mem_busy && !flush && !load_use;
    stall    = id_valid && !id_ready && !flush;

    // Only the EX producer is forwarded; a WB producer has already written the
    // regfile by the time the consumer reads it in EX.
    fwd_a_nxt = ex_valid && ex_is_alu && hit_rs1;
    fwd_b_nxt = ex_valid && ex_is_alu && hit_rs2;

    wb_en = wb_valid && !mem_busy;
    wb_rd = wb_rd_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ex_opcode <= '0;
      ex_rd     <= '0;
      ex_fwd_a  <= 1'b0;
      ex_fwd_b  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd_q   <= '0;
    end else if (!mem_busy) begin
      // Opcode 0 / undefined occupies EX but never reaches the write port.
      wb_valid <= ex_writes;
      wb_rd_q  <= ex_rd;
      if (id_ready) begin
        ex_valid  <= 1'b1;
        ex_opcode <= id_opcode;
        ex_rd     <= id_rd;
        ex_fwd_a  <= fwd_a_nxt;
        ex_fwd_b  <= fwd_b_nxt;
      end else begin
        ex_valid  <= 1'b0;
        ex_fwd_a  <= 1'b0;
        ex_fwd_b  <= 1'b0;
      end
    end
  end

`ifdef HAZ_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles    <= '0;
      load_use_cycles <= '0;
      freeze_cycles   <= '0;
    end else begin
      if (stall && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
      if (load_use && (load_use_cycles != 16'hFFFF))
        load_use_cycles <= load_use_cycles + 16'd1;
      if (mem_busy && (freeze_cycles != 16'hFFFF))
        freeze_cycles <= freeze_cycles + 16'd1;
    end
  end
`endif

endmodule
